// File: rtl/stc_seq.sv
// APB-master sequencer replaying a register-write table into the stc block.
// Passes start on command or on a selected timer interrupt edge.
module stc_seq #(
  parameter int DEPTH = 16,
  parameter int IW    = 4
) (
  input  logic          pclk,
  input  logic          preset,
  input  logic          tbl_we,
  input  logic [IW-1:0] tbl_widx,
  input  logic [9:0]    tbl_wpaddr,
  input  logic [31:0]   tbl_wdata,
  input  logic [IW:0]   cfg_len,
  input  logic          cfg_loop,
  input  logic          cfg_trig_en,
  input  logic [1:0]    cfg_trig_sel,
  input  logic          start,
  input  logic          stop,
  input  logic [3:0]    timer_int,
  output logic          m_psel,
  output logic          m_penable,
  output logic          m_pwrite,
  output logic [9:0]    m_paddr,
  output logic [31:0]   m_pwdata,
  input  logic          m_pready,
  output logic          busy,
  output logic          done,
  output logic [7:0]    ovr_cnt,
  input  logic          ovr_clr
);

  typedef enum logic [1:0] {
    IDLE, ARM, SETUP, ACCESS
  } state_t;

  localparam logic [IW:0] ONE = 1;

  logic [41:0]   tbl [DEPTH];
  state_t        state, state_n;
  logic [IW-1:0] idx, idx_n;
  logic [IW:0]   len_q;
  logic          loop_q, trig_q;
  logic [1:0]    sel_q;
  logic          stop_q, stop_n;
  logic [3:0]    tprev;
  logic          edge_hit, last, accept;
  logic          ovr_inc, done_n;
  logic          psel_n, penable_n, busy_n, load_n;
  logic [41:0]   rd;

  assign edge_hit = timer_int[sel_q] & ~tprev[sel_q];
  assign last     = ({1'b0, idx} + ONE) == len_q;
  assign accept   = (state == IDLE) && start && !stop;
  assign ovr_inc  = trig_q && edge_hit &&
                    (state == SETUP || state == ACCESS);

  // Table storage; deliberately not reset
  always_ff @(posedge pclk) begin
    if (tbl_we) tbl[tbl_widx] <= {tbl_wpaddr, tbl_wdata};
  end

  // State, index, latched config and overrun counter
  always_ff @(posedge pclk) begin
    if (preset) begin
      state   <= IDLE;
      idx     <= '0;
      len_q   <= '0;
      loop_q  <= 1'b0;
      trig_q  <= 1'b0;
      sel_q   <= 2'd0;
      stop_q  <= 1'b0;
      tprev   <= 4'd0;
      ovr_cnt <= 8'd0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      stop_q <= stop_n;
      tprev  <= timer_int;
      if (accept) begin
        len_q  <= cfg_len;
        loop_q <= cfg_loop;
        trig_q <= cfg_trig_en;
        sel_q  <= cfg_trig_sel;
      end
      if (ovr_clr)
        ovr_cnt <= 8'd0;
      else if (ovr_inc && ovr_cnt != 8'hff)
        ovr_cnt <= ovr_cnt + 8'd1;
    end
  end

  // Next state; a stop seen mid-transfer waits for pready
  always_comb begin
    state_n = state;
    idx_n   = idx;
    stop_n  = stop_q;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        stop_n = 1'b0;
        if (start && !stop) begin
          if (cfg_len == '0) begin
            done_n = 1'b1;
          end else begin
            idx_n   = '0;
            state_n = cfg_trig_en ? ARM : SETUP;
          end
        end
      end
      ARM: begin
        if (stop) begin
          state_n = IDLE;
          idx_n   = '0;
        end else if (edge_hit) begin
          state_n = SETUP;
        end
      end
      SETUP: begin
        if (stop) stop_n = 1'b1;
        state_n = ACCESS;
      end
      ACCESS: begin
        if (stop) stop_n = 1'b1;
        if (m_pready) begin
          if (stop_q || stop) begin
            state_n = IDLE;
            idx_n   = '0;
            stop_n  = 1'b0;
          end else if (!last) begin
            idx_n   = idx + 1'b1;
            state_n = SETUP;
          end else begin
            idx_n  = '0;
            done_n = 1'b1;
            if (!loop_q)
              state_n = IDLE;
            else
              state_n = trig_q ? ARM : SETUP;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    psel_n    = (state_n == SETUP) || (state_n == ACCESS);
    penable_n = (state_n == ACCESS);
    busy_n    = (state_n != IDLE);
    load_n    = (state_n == SETUP);
    rd        = tbl[idx_n];
  end

  // Output registers; address/data hold after the last transfer
  always_ff @(posedge pclk) begin
    if (preset) begin
      m_psel    <= 1'b0;
      m_penable <= 1'b0;
      m_pwrite  <= 1'b0;
      m_paddr   <= 10'd0;
      m_pwdata  <= 32'd0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      m_psel    <= psel_n;
      m_penable <= penable_n;
      m_pwrite  <= psel_n;
      busy      <= busy_n;
      done      <= done_n;
      if (load_n) begin
        m_paddr  <= rd[41:32];
        m_pwdata <= rd[31:0];
      end
    end
  end

endmodule

// File: doc/stc_seq.md
Name: stc_seq

Overview:
- APB-master sequencer that programs the system timer/PWM block (stc) without CPU involvement.
- Holds a 16-entry table of {register word index, data} pairs. On a start command, or on a selected timer interrupt edge, it replays entries 0..len-1 as APB writes.
- Typical use: glitch-free multi-channel PWM duty/frequency updates aligned to a timer tick.
- Sits between the system APB fabric and the stc slave port.

Parameters:
- DEPTH, 16, table entries; power of two, at most 16.
- IW, 4, table index width (log2 DEPTH).

Ports:
- pclk  in  1  single clock for all logic.
- preset  in  1  reset; synchronous, active-high.
- tbl_we  in  1  table write strobe.
- tbl_widx  in  IW  table entry index to write.
- tbl_wpaddr  in  10  APB word address (paddr[11:2]) stored in the entry.
- tbl_wdata  in  32  write data stored in the entry.
- cfg_len  in  IW+1  number of entries per pass; 0..DEPTH.
- cfg_loop  in  1  1 = repeat passes until stop.
- cfg_trig_en  in  1  1 = each pass waits for a timer edge.
- cfg_trig_sel  in  2  selects which timer_int bit triggers.
- start  in  1  one-cycle start pulse.
- stop  in  1  one-cycle stop pulse.
- timer_int  in  4  timer interrupt levels from stc.
- m_psel  out  1  APB select.
- m_penable  out  1  APB enable.
- m_pwrite  out  1  APB write; always 1 while m_psel is high.
- m_paddr  out  10  APB word address.
- m_pwdata  out  32  APB write data.
- m_pready  in  1  APB ready.
- busy  out  1  high whenever the state is not IDLE.
- done  out  1  one-cycle pulse at the end of each completed pass.
- ovr_cnt  out  8  saturating count of trigger overruns.
- ovr_clr  in  1  clears ovr_cnt.

Behaviour:
- All outputs are registered.
- Reset values: m_psel=0, m_penable=0, m_pwrite=0, m_paddr=0, m_pwdata=0, busy=0, done=0, ovr_cnt=0, state=IDLE, idx=0, edge-detect register=0.
- Table contents are not reset.
- States: IDLE, ARM, SETUP, ACCESS.
- IDLE:
  - start with latched len=0 → done pulses next cycle; state stays IDLE.
  - start with len>0 → latch cfg_len, cfg_loop, cfg_trig_en, cfg_trig_sel; set idx=0; go to ARM if trig_en, else SETUP.
- ARM:
  - Wait for a rising edge: timer_int[sel]=1 and previous-cycle value=0.
  - A level that is already high on entry is not an edge.
  - On edge → SETUP.
- SETUP (one cycle): m_psel=1, m_penable=0, m_pwrite=1; m_paddr/m_pwdata loaded from table[idx]. Next state is ACCESS.
- ACCESS: m_psel=1, m_penable=1; hold all APB outputs until m_pready=1.
  - On pready, if idx<len-1: idx+1 → SETUP.
  - On pready, if idx=len-1: pulse done next cycle and set idx=0.
    - loop=1 → ARM (trig_en) or SETUP (no trig).
    - loop=0 → IDLE.
- On leaving ACCESS to IDLE, m_psel, m_penable and m_pwrite drop to 0 together. m_paddr and m_pwdata hold their last values.
- Latency with no trigger and pready=1: start sampled at edge N gives first SETUP at N+1. Each transfer takes 2 cycles. For len entries, done is high at N+1+2·len.
- stop:
  - In IDLE or ARM → IDLE next cycle, no done pulse.
  - In SETUP or ACCESS → the current transfer completes normally (an APB transfer is never aborted), then IDLE with no done pulse.
- start while busy is ignored. start and stop in the same cycle: stop wins, so start is ignored.
- Trigger overrun: a selected edge while in SETUP or ACCESS with trig_en latched increments ovr_cnt, saturating at 255. The edge is otherwise discarded.
- ovr_clr has priority over a simultaneous increment; the result is 0.
- Table writes are allowed while busy.
  - An entry is read when SETUP is entered.
  - A write to the same entry in that same cycle is not seen; the old value is used.
- Mid-operation reset: returns to reset values in one cycle; the APB outputs deassert immediately.
- idx and len arithmetic is unsigned. idx never exceeds len-1.

Test Plan:
- Table {0x006:0x0003E8, 0x00B:0x0001F4, 0x000:0x01001}, len=3, no trig, pready=1, start at N → writes appear in order, SETUP at N+1/N+3/N+5, done at N+7, busy low at N+7.
- Same table, pready held low 3 cycles in the second ACCESS → m_paddr=0x00B and m_pwdata held stable, m_penable=1 throughout, done delayed to N+10.
- trig_en=1, sel=2, loop=1, len=2; timer_int[2] already high at start → no transfer. Drop it, then give 3 rising edges → 3 passes, 3 done pulses, ovr_cnt=0.
- Same setup, second edge arrives during ACCESS of pass 1 → ovr_cnt=1, pass count unchanged. Assert ovr_clr → ovr_cnt=0.
- stop during SETUP of entry 1 with len=3 → entry 1 write completes, entry 2 is never issued, no done pulse, busy=0 the cycle after ACCESS.
- len=0 start → done pulses one cycle and busy stays 0. preset asserted during ACCESS → m_psel=0 next cycle, all outputs at reset values.
